// File: rtl/traffic_light_pkg.sv
// traffic_light_pkg: phase/lamp encodings and default dwell times shared by the controller and the monitor.
package traffic_light_pkg;

    typedef enum logic [1:0] {
        STOP      = 2'b00,
        GET_READY = 2'b01,
        GO        = 2'b10,
        SLOW_DOWN = 2'b11
    } phase_t;

    typedef enum logic [1:0] {
        SYNC,
        TRACK,
        FAULT_HOLD
    } state_t;

    // lamp patterns as {red, yellow, green}
    localparam logic [2:0] PAT_STOP      = 3'b100;
    localparam logic [2:0] PAT_GET_READY = 3'b110;
    localparam logic [2:0] PAT_GO        = 3'b001;
    localparam logic [2:0] PAT_SLOW_DOWN = 3'b010;

    localparam int DEF_STOP_CYC  = 5;
    localparam int DEF_READY_CYC = 3;
    localparam int DEF_GO_CYC    = 7;
    localparam int DEF_SLOW_CYC  = 3;

    // phases advance in encoding order and wrap from SLOW_DOWN back to STOP
    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

endpackage

// File: rtl/traffic_light_decode.sv
// traffic_light_decode: combinational lamp pattern -> {phase, legal} decoder.
module traffic_light_decode
    import traffic_light_pkg::*;
(
    input  logic [2:0] lamps,
    output phase_t     phase,
    output logic       legal
);

    always_comb begin
        legal = lamps inside {PAT_STOP, PAT_GET_READY, PAT_GO, PAT_SLOW_DOWN};
        phase = lamps == PAT_GET_READY ? GET_READY :
                lamps == PAT_GO        ? GO        :
                lamps == PAT_SLOW_DOWN ? SLOW_DOWN : STOP;
    end

endmodule

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: checks lamp sequence, dwell times and pattern legality of a traffic light controller.
module traffic_light_monitor
    import traffic_light_pkg::*;
#(
    parameter int STOP_CYC  = DEF_STOP_CYC,
    parameter int READY_CYC = DEF_READY_CYC,
    parameter int GO_CYC    = DEF_GO_CYC,
    parameter int SLOW_CYC  = DEF_SLOW_CYC
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       red,
    input  logic       yellow,
    input  logic       green,
    input  logic       clear_fault,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic [3:0] dwell,
    output logic       seq_err,
    output logic       dwell_err,
    output logic       pattern_err,
    output logic       fault,
    output logic       cycle_done,
    output logic [7:0] cycle_count
);

    localparam logic [3:0] C_STOP  = 4'(STOP_CYC);
    localparam logic [3:0] C_READY = 4'(READY_CYC);
    localparam logic [3:0] C_GO    = 4'(GO_CYC);
    localparam logic [3:0] C_SLOW  = 4'(SLOW_CYC);

    state_t     state, state_n;
    phase_t     phase_q, phase_n, dec_phase;
    logic       dec_legal, legal_q;
    logic [2:0] lamps, pat_q;
    logic       has_prev, changed, legal_chg, checking, err;
    logic       seq_n, dwell_err_n, pattern_err_n, done_n, fault_n, valid_n;
    logic [3:0] cur_cyc, dwell_n;
    logic [7:0] count_n;

    assign lamps = {red, yellow, green};
    assign phase = phase_q;

    traffic_light_decode u_decode (
        .lamps (lamps),
        .phase (dec_phase),
        .legal (dec_legal)
    );

    // dwell is 0 only straight after reset, so it doubles as "no sample seen yet"
    always_comb begin
        has_prev      = dwell != 4'd0;
        changed       = !has_prev || lamps != pat_q;
        legal_chg     = changed && has_prev && legal_q && dec_legal;
        checking      = state != SYNC;
        cur_cyc       = phase_q == STOP      ? C_STOP  :
                        phase_q == GET_READY ? C_READY :
                        phase_q == GO        ? C_GO    : C_SLOW;
        seq_n         = checking && legal_chg && dec_phase != next_phase(phase_q);
        dwell_err_n   = checking && legal_q && has_prev &&
                        (legal_chg ? dwell != cur_cyc : !changed && dwell == cur_cyc);
        pattern_err_n = changed && !dec_legal;
        err           = seq_n || dwell_err_n || pattern_err_n;
        done_n        = checking && legal_chg && phase_q == SLOW_DOWN && dec_phase == STOP && !err;
        state_n       = state == SYNC ? (legal_chg ? TRACK : SYNC) :
                        (changed && has_prev && !legal_q && dec_legal) ? SYNC :
                        err ? FAULT_HOLD :
                        (state == FAULT_HOLD && clear_fault) ? TRACK : state;
        dwell_n       = changed ? 4'd1 : (dwell == 4'd15 ? dwell : dwell + 4'd1);
        phase_n       = dec_legal ? dec_phase : phase_q;
        valid_n       = dec_legal && state_n == TRACK;
        fault_n       = err || (fault && !clear_fault);
        count_n       = done_n && cycle_count != 8'hff ? cycle_count + 8'd1 : cycle_count;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= SYNC;
            pat_q       <= 3'd0;
            legal_q     <= 1'b0;
            phase_q     <= STOP;
            phase_valid <= 1'b0;
            dwell       <= 4'd0;
            seq_err     <= 1'b0;
            dwell_err   <= 1'b0;
            pattern_err <= 1'b0;
            fault       <= 1'b0;
            cycle_done  <= 1'b0;
            cycle_count <= 8'd0;
        end else begin
            state       <= state_n;
            pat_q       <= lamps;
            legal_q     <= dec_legal;
            phase_q     <= phase_n;
            phase_valid <= valid_n;
            dwell       <= dwell_n;
            seq_err     <= seq_n;
            dwell_err   <= dwell_err_n;
            pattern_err <= pattern_err_n;
            fault       <= fault_n;
            cycle_done  <= done_n;
            cycle_count <= count_n;
        end
    end

endmodule

// File: doc/traffic_light_monitor.md
TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

Interface
REQ-001 Parameter STOP_CYC, default 5: required STOP dwell in clk cycles (legal range 1..14).
REQ-002 Parameter READY_CYC, default 3: required GET_READY dwell in cycles.
REQ-003 Parameter GO_CYC, default 7: required GO dwell in cycles.
REQ-004 Parameter SLOW_CYC, default 3: required SLOW_DOWN dwell in cycles.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 reset  input  1  synchronous, active-low reset; sampled only on rising clk.
REQ-007 red, yellow, green  input  1 each  lamp lines from the traffic light controller.
REQ-008 clear_fault  input  1  clears the sticky fault flag.
REQ-009 phase  output  2  decoded phase: 00 STOP, 01 GET_READY, 10 GO, 11 SLOW_DOWN.
REQ-010 phase_valid  output  1  lamp pattern is legal and the monitor is in TRACK.
REQ-011 dwell  output  4  cycles spent in the current pattern, saturating at 15.
REQ-012 seq_err, dwell_err, pattern_err  output  1 each  single-cycle error pulses.
REQ-013 fault  output  1  sticky OR of all error pulses.
REQ-014 cycle_done  output  1  single-cycle pulse on each legal SLOW_DOWN->STOP transition.
REQ-015 cycle_count  output  8  count of cycle_done pulses, saturating at 255.

Function
REQ-016 Pattern decode {red,yellow,green}: 100 STOP, 110 GET_READY, 001 GO, 010 SLOW_DOWN; all other patterns are illegal.
REQ-017 All outputs are registered; lamp inputs sampled at edge k are reflected in outputs after edge k (1-cycle latency).
REQ-018 FSM states: SYNC, TRACK, FAULT_HOLD.
REQ-019 SYNC: entered on reset; on the first sampled legal pattern change, go to TRACK; the partial first run is not dwell-checked.
REQ-020 TRACK: legal successor order STOP->GET_READY->GO->SLOW_DOWN->STOP; any other change of legal pattern pulses seq_err.
REQ-021 On a legal pattern change, the completed run length must equal the phase's *_CYC value; otherwise pulse dwell_err, including early exit.
REQ-022 While a pattern holds, pulse dwell_err once, at the cycle its run length reaches *_CYC+1 (overstay); no repeat until the next change.
REQ-023 An illegal pattern pulses pattern_err on entry only; phase_valid=0 while illegal; the next legal pattern moves the FSM to SYNC.
REQ-024 Any error pulse sets fault and moves TRACK to FAULT_HOLD; FAULT_HOLD keeps decoding and checking and returns to TRACK when clear_fault=1.
REQ-025 clear_fault with a simultaneous error: the error wins; fault remains 1.
REQ-026 dwell resets to 1 on each pattern change and otherwise increments, saturating at 15; compare against the unsaturated comparison range (*_CYC <= 14).
REQ-027 seq_err and dwell_err may pulse in the same cycle; cycle_done is suppressed if either is set.
REQ-028 phase holds its last legal value while the pattern is illegal.

Reset
REQ-029 With reset=0 at an edge: state=SYNC, phase=00, phase_valid=0, dwell=0, all error pulses=0, fault=0, cycle_done=0, cycle_count=0.
REQ-030 Reset mid-operation discards all history; checking restarts as in REQ-019.

Structure
REQ-031 Phase encodings, lamp pattern constants, and default dwell constants live in the shared package traffic_light_pkg, also used by the controller.
REQ-032 One sub-module, traffic_light_decode: a combinational pattern->{phase, legal} decoder.

Verification
REQ-033 Defaults, lamps driven STOP5/READY3/GO7/SLOW3 for two full cycles -> no errors; cycle_done pulses once per cycle; cycle_count=1 after the first full cycle.
REQ-034 GO held for 4 cycles, then SLOW_DOWN -> dwell_err pulses 1 cycle after SLOW_DOWN is sampled; fault=1.
REQ-035 STOP held for 8 cycles -> dwell_err pulse when dwell reaches 6; single pulse only.
REQ-036 STOP->GO directly -> seq_err=1; pattern 111 -> pattern_err=1, phase_valid=0, phase unchanged.
REQ-037 clear_fault=1 in the same cycle as a new seq_err -> fault stays 1; clear_fault alone on the next cycle -> fault=0, state TRACK.
REQ-038 reset=0 during GO with fault=1 -> all outputs at REQ-029 values; a first partial run after release produces no dwell_err.
